// File: rtl/jtag_uart_ctrl_pkg.sv
// jtag_uart_ctrl_pkg: shared states, register map and ASCII constants for the JTAG UART sequencer
package jtag_uart_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, RD_DATA, RD_CTRL, WR_DATA} state_t;
  localparam logic ADDR_DATA = 1'b0;
  localparam logic ADDR_CTRL = 1'b1;
  localparam int RVALID_BIT = 15;
  localparam int WSPACE_MSB = 31;
  localparam int WSPACE_LSB = 16;
  localparam logic [7:0] ASCII_0 = 8'h30;
  localparam logic [7:0] ASCII_1 = 8'h31;
  localparam logic [7:0] ASCII_2 = 8'h32;
  localparam int MSG_LEN = 5;
  localparam logic [7:0] MSG [MSG_LEN] = '{8'h42, 8'h54, 8'h4E, 8'h0D, 8'h0A};
endpackage

// File: rtl/jtag_uart_ctrl_debounce.sv
// button_debounce: synchronises an active-low button and emits a one-cycle pulse on each accepted press
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic button,
  output logic press
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  logic [1:0] sync;
  logic level;
  logic [CW-1:0] cnt;
  always_ff @(posedge clk) begin
    if (reset) begin
      sync  <= 2'b11;
      level <= 1'b1;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync  <= {sync[0], button};
      press <= 1'b0;
      if (sync[1] == level) cnt <= '0;
      else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        level <= sync[1];
        cnt   <= '0;
        press <= !sync[1];
      end else cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/jtag_uart_ctrl.sv
// jtag_uart_ctrl: Avalon-MM master that polls the JTAG UART, echoes RX chars, drives LEDs and sends "BTN\r\n"
module jtag_uart_ctrl
  import jtag_uart_ctrl_pkg::*;
#(
  parameter int POLL_CYCLES     = 64,
  parameter int DEBOUNCE_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        button,
  output logic        av_address,
  output logic        av_read,
  output logic        av_write,
  output logic [31:0] av_writedata,
  input  logic [31:0] av_readdata,
  input  logic        av_waitrequest,
  output logic        led0,
  output logic        led1,
  output logic        led2
);
  localparam int CW = $clog2(POLL_CYCLES + 1);
  state_t state;
  logic [CW-1:0] cnt;
  logic [7:0] rx_char;
  logic [2:0] idx;
  logic echo_pending, btn_pending, hold, sel_echo, press, pending, unused;
  logic [7:0] rd_char;
  assign pending = echo_pending | btn_pending;
  assign rd_char = av_readdata[7:0];
  assign unused  = ^av_readdata[14:8];
  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
    .clk(clk), .reset(reset), .button(button), .press(press)
  );
  // Every bus state issues its strobe one cycle after entry unless IDLE already raised it,
  // so a completed strobe always drops for at least one cycle before the next access.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      rx_char      <= '0;
      idx          <= '0;
      echo_pending <= 1'b0;
      btn_pending  <= 1'b0;
      hold         <= 1'b0;
      sel_echo     <= 1'b0;
      av_address   <= ADDR_DATA;
      av_read      <= 1'b0;
      av_write     <= 1'b0;
      av_writedata <= '0;
      led0         <= 1'b0;
      led1         <= 1'b0;
      led2         <= 1'b0;
    end else begin
      if (press) btn_pending <= 1'b1;
      case (state)
        IDLE:
          if ((pending && !hold) || cnt == CW'(POLL_CYCLES)) begin
            state      <= pending ? RD_CTRL : RD_DATA;
            av_read    <= 1'b1;
            av_address <= pending ? ADDR_CTRL : ADDR_DATA;
            cnt        <= '0;
            hold       <= 1'b0;
          end else cnt <= cnt + 1'b1;
        RD_DATA:
          if (!av_read) begin
            av_read    <= 1'b1;
            av_address <= ADDR_DATA;
          end else if (!av_waitrequest) begin
            av_read <= 1'b0;
            if (av_readdata[RVALID_BIT]) begin
              rx_char      <= rd_char;
              echo_pending <= 1'b1;
              led0         <= led0 ^ (rd_char == ASCII_0);
              led1         <= led1 ^ (rd_char == ASCII_1);
              led2         <= led2 ^ (rd_char == ASCII_2);
              state        <= RD_CTRL;
            end else state <= IDLE;
          end
        RD_CTRL:
          if (!av_read) begin
            av_read    <= 1'b1;
            av_address <= ADDR_CTRL;
          end else if (!av_waitrequest) begin
            av_read <= 1'b0;
            hold    <= av_readdata[WSPACE_MSB:WSPACE_LSB] == '0;
            state   <= av_readdata[WSPACE_MSB:WSPACE_LSB] == '0 ? IDLE : WR_DATA;
          end
        WR_DATA:
          if (!av_write) begin
            av_write     <= 1'b1;
            av_address   <= ADDR_DATA;
            sel_echo     <= echo_pending;
            av_writedata <= {24'd0, echo_pending ? rx_char : MSG[idx]};
          end else if (!av_waitrequest) begin
            av_write <= 1'b0;
            if (sel_echo) begin
              echo_pending <= 1'b0;
              state        <= RD_DATA;
            end else begin
              btn_pending <= idx != 3'(MSG_LEN - 1);
              idx         <= idx == 3'(MSG_LEN - 1) ? 3'd0 : idx + 3'd1;
              state       <= IDLE;
            end
          end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_jtag_uart_ctrl.sv
// tb_jtag_uart_ctrl: scoreboard bench with a behavioural JTAG UART slave and LED/write expectation queues
module tb_jtag_uart_ctrl;
  localparam int POLL = 8;
  localparam int DB   = 16;
  logic clk = 0, reset = 1, button = 1, av_waitrequest = 0;
  logic av_address, av_read, av_write, led0, led1, led2;
  logic [31:0] av_writedata, av_readdata = '0;
  int checks = 0, errors = 0, wait_n = 0, wcnt = 0, cyc = 0, last_poll = -1, npolls = 0;
  bit check_period = 0;
  logic [7:0] rx_q[$], exp_q[$];
  logic [15:0] wsp_q[$];
  logic [7:0] rc;
  logic [2:0] exp_led = '0;
  logic prev_stall = 0, prev_rd = 0, prev_wr = 0, prev_addr = 0;
  logic [31:0] prev_wd = '0;
  logic [7:0] msg [5] = '{8'h42, 8'h54, 8'h4E, 8'h0D, 8'h0A};

  jtag_uart_ctrl #(.POLL_CYCLES(POLL), .DEBOUNCE_CYCLES(DB)) dut (
    .clk(clk), .reset(reset), .button(button), .av_address(av_address), .av_read(av_read),
    .av_write(av_write), .av_writedata(av_writedata), .av_readdata(av_readdata),
    .av_waitrequest(av_waitrequest), .led0(led0), .led1(led1), .led2(led2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Slave model and monitor: responds to strobes, pops expected writes, tracks expected LEDs.
  always @(negedge clk) begin
    #1;
    cyc++;
    chk("leds", {29'd0, led2, led1, led0}, {29'd0, exp_led});
    if (prev_stall) begin
      chk("hold_rd", av_read, prev_rd);
      chk("hold_wr", av_write, prev_wr);
      chk("hold_addr", av_address, prev_addr);
      chk("hold_wdata", av_writedata, prev_wd);
    end
    if (av_read || av_write) chk("rw_excl", av_read & av_write, 0);
    if (check_period && av_read && !prev_rd && av_address == 1'b0) begin
      if (last_poll >= 0) chk("poll_period", cyc - last_poll, POLL + 2);
      last_poll = cyc;
      npolls++;
    end
    av_readdata = '0;
    if ((av_read || av_write) && wcnt < wait_n) begin
      av_waitrequest = 1;
      wcnt++;
    end else begin
      av_waitrequest = 0;
      wcnt = 0;
      if (av_read && av_address) av_readdata[31:16] = wsp_q.size() != 0 ? wsp_q.pop_front() : 16'd64;
      else if (av_read && rx_q.size() != 0) begin
        rc = rx_q.pop_front();
        av_readdata[15] = 1'b1;
        av_readdata[7:0] = rc;
        exp_led ^= {rc == 8'h32, rc == 8'h31, rc == 8'h30};
      end else if (av_write) begin
        chk("wr_addr", av_address, 0);
        if (exp_q.size() != 0) chk("wdata", av_writedata, exp_q.pop_front());
        else begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got %h expected none", av_writedata);
        end
      end
    end
    prev_stall = (av_read || av_write) && av_waitrequest;
    prev_rd = av_read;
    prev_wr = av_write;
    prev_addr = av_address;
    prev_wd = av_writedata;
  end

  task automatic drain(input int max);
    int n = 0;
    while ((exp_q.size() + rx_q.size() + wsp_q.size()) != 0 && n < max) begin
      @(negedge clk);
      n++;
    end
    chk("drain_exp", exp_q.size(), 0);
    chk("drain_rx", rx_q.size(), 0);
    chk("drain_wsp", wsp_q.size(), 0);
    repeat (30) @(negedge clk);
  endtask

  task automatic press();
    button = 0;
    repeat (2 * DB) @(negedge clk);
    button = 1;
  endtask

  initial begin
    bit found = 0;
    repeat (3) @(negedge clk);
    #2;
    chk("rst_read", av_read, 0);
    chk("rst_write", av_write, 0);
    chk("rst_addr", av_address, 0);
    chk("rst_wdata", av_writedata, 0);
    chk("rst_leds", {led2, led1, led0}, 0);
    reset = 0;
    check_period = 1;
    repeat (45) @(negedge clk);
    check_period = 0;
    chk("poll_count", npolls >= 3, 1);
    exp_q.push_back(8'h31); rx_q.push_back(8'h31);
    drain(200);
    chk("led1_on", led1, 1);
    exp_q.push_back(8'h31); rx_q.push_back(8'h31);
    drain(200);
    chk("led1_off", led1, 0);
    wait_n = 5;
    exp_q.push_back(8'h41); rx_q.push_back(8'h41);
    drain(400);
    chk("leds_41", {led2, led1, led0}, 0);
    wait_n = 0;
    foreach (msg[i]) exp_q.push_back(msg[i]);
    press();
    drain(600);
    button = 0;
    repeat (10) @(negedge clk);
    button = 1;
    repeat (80) @(negedge clk);
    wsp_q.push_back(0); wsp_q.push_back(0); wsp_q.push_back(0); wsp_q.push_back(16);
    rx_q.push_back(8'h32); exp_q.push_back(8'h32);
    drain(400);
    chk("led2_on", led2, 1);
    wait_n = 5;
    foreach (msg[i]) exp_q.push_back(msg[i]);
    button = 0;
    for (int n = 0; n < 800 && !found; n++) begin
      @(negedge clk);
      #2;
      found = av_write && av_writedata == 32'h4E;
    end
    chk("found_4e", found, 1);
    reset = 1;
    button = 1;
    exp_led = '0;
    prev_stall = 0;
    @(negedge clk);
    #2;
    reset = 0;
    exp_q.delete();
    chk("rst_wr_drop", av_write, 0);
    chk("rst_mid_leds", {led2, led1, led0}, 0);
    wait_n = 0;
    foreach (msg[i]) exp_q.push_back(msg[i]);
    press();
    drain(600);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
